// File: rtl/axi4_slave_ram.sv
// axi4_slave_ram: AXI4 subordinate RAM with independent write and read FSMs.
// Supports single-beat and FIXED/INCR bursts (WRAP handled as INCR).
// Optional feature: define AXI_SLAVE_RANGE_CHECK_EN to flag word indices
// >= MEM_DEPTH with SLVERR (write suppressed, read data zero) instead of aliasing.
module axi4_slave_ram #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MEM_DEPTH  = 1024
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int unsigned IW = ADDR_WIDTH - 2;
  localparam int unsigned MW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  w_state_t          w_state, w_state_n;
  r_state_t          r_state, r_state_n;
  logic [IW-1:0]     widx, ridx, r_load_idx;
  logic [7:0]        wlen, wcnt, rlen, rcnt;
  logic [1:0]        wburst, rburst;
  logic [ID_WIDTH-1:0] wid;
  logic              werr, w_ok, r_ok;
  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic              unused_inputs;

  assign unused_inputs = ^{s_axi_awsize, s_axi_arsize, s_axi_wlast,
                           s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid  && s_axi_wready;
  assign b_hs  = s_axi_bvalid  && s_axi_bready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign r_hs  = s_axi_rvalid  && s_axi_rready;

  function automatic logic [IW-1:0] next_index(input logic [IW-1:0] idx, input logic [1:0] burst);
    return (burst == 2'b00) ? idx : idx + IW'(1);
  endfunction

  function automatic logic [MW-1:0] mem_slot(input logic [IW-1:0] idx);
    logic [IW-1:0] m;
    m = idx % IW'(MEM_DEPTH);
    return m[MW-1:0];
  endfunction

  // Index of the read beat being loaded next, and in-range flags for both paths
  always_comb begin
    r_load_idx = (r_state == R_IDLE) ? s_axi_araddr[ADDR_WIDTH-1:2] : next_index(ridx, rburst);
`ifdef AXI_SLAVE_RANGE_CHECK_EN
    w_ok = (widx < IW'(MEM_DEPTH));
    r_ok = (r_load_idx < IW'(MEM_DEPTH));
`else
    w_ok = 1'b1;
    r_ok = 1'b1;
`endif
  end

  // FSM state registers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_n;
      r_state <= r_state_n;
    end
  end

  // Write FSM next-state: burst length alone ends the data phase
  always_comb begin
    w_state_n = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_hs) w_state_n = W_DATA;
      W_DATA:  if (w_hs && (wcnt == wlen)) w_state_n = W_RESP;
      W_RESP:  if (b_hs) w_state_n = W_IDLE;
      default: w_state_n = W_IDLE;
    endcase
  end

  // Read FSM next-state
  always_comb begin
    r_state_n = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs) r_state_n = R_DATA;
      R_DATA:  if (r_hs && s_axi_rlast) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end

  // Write channel handshakes, burst tracking and B response
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= '0;
      widx          <= '0;
      wlen          <= '0;
      wburst        <= '0;
      wcnt          <= '0;
      wid           <= '0;
      werr          <= 1'b0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            wid           <= s_axi_awid;
            widx          <= s_axi_awaddr[ADDR_WIDTH-1:2];
            wlen          <= s_axi_awlen;
            wburst        <= s_axi_awburst;
            wcnt          <= '0;
            werr          <= 1'b0;
          end else begin
            s_axi_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            widx <= next_index(widx, wburst);
            wcnt <= wcnt + 8'd1;
            if (!w_ok) werr <= 1'b1;
            if (wcnt == wlen) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bid    <= wid;
              s_axi_bresp  <= (werr || !w_ok) ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        W_RESP: begin
          if (b_hs) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Array write with byte strobes; no write while reset is asserted
  always_ff @(posedge aclk) begin
    if (aresetn && w_hs && w_ok) begin
      for (int unsigned i = 0; i < SW; i++) begin
        if (s_axi_wstrb[i]) mem[mem_slot(widx)][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
  end

  // Read channel: AR capture and beat sequencing, R outputs held while stalled
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rresp   <= '0;
      s_axi_rdata   <= '0;
      ridx          <= '0;
      rlen          <= '0;
      rburst        <= '0;
      rcnt          <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rid     <= s_axi_arid;
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            s_axi_rdata   <= r_ok ? mem[mem_slot(r_load_idx)] : '0;
            s_axi_rresp   <= r_ok ? RESP_OKAY : RESP_SLVERR;
            ridx          <= r_load_idx;
            rlen          <= s_axi_arlen;
            rburst        <= s_axi_arburst;
            rcnt          <= '0;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
            end else begin
              ridx        <= r_load_idx;
              rcnt        <= rcnt + 8'd1;
              s_axi_rlast <= ((rcnt + 8'd1) == rlen);
              s_axi_rdata <= r_ok ? mem[mem_slot(r_load_idx)] : '0;
              s_axi_rresp <= r_ok ? RESP_OKAY : RESP_SLVERR;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_slave_ram.sv
// Directed self-checking bench for axi4_slave_ram (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_axi4_slave_ram;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  s_axi_awid;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [3:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [3:0]  s_axi_arid;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [3:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  axi4_slave_ram #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_DEPTH(1024)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int passed = 0;

  // write helper state
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  int          b_hold_err, aw_err;
  bit          w_tmo, w_first, b_after;

  // read helper state
  logic [31:0] rd_d    [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id   [16];
  int          rd_n, r_hold_err;
  bit          r_tmo, r_first;

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [3:0] id, input int bdelay);
    int t;
    w_tmo = 0; b_hold_err = 0; aw_err = 0;
    @(negedge aclk);
    s_axi_awvalid = 1'b1; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awburst = burst; s_axi_awid = id; s_axi_awsize = 3'd2;
    t = 0;
    while (!s_axi_awready && t < 50) begin @(negedge aclk); t++; end
    if (t >= 50) w_tmo = 1;
    @(negedge aclk);
    s_axi_awvalid = 1'b0;
    w_first = s_axi_wready;
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wvalid = 1'b1; s_axi_wdata = wd[i]; s_axi_wstrb = ws[i];
      s_axi_wlast = (i == int'(len));
      t = 0;
      while (!s_axi_wready && t < 50) begin @(negedge aclk); t++; end
      if (t >= 50) w_tmo = 1;
      @(negedge aclk);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    t = 0;
    while (!s_axi_bvalid && t < 50) begin @(negedge aclk); t++; end
    if (t >= 50) w_tmo = 1;
    b_id = s_axi_bid; b_resp = s_axi_bresp;
    for (int d = 0; d < bdelay; d++) begin
      if (!s_axi_bvalid || s_axi_bid !== b_id || s_axi_bresp !== b_resp) b_hold_err++;
      if (s_axi_awready) aw_err++;
      @(negedge aclk);
    end
    s_axi_bready = 1'b1;
    @(negedge aclk);
    s_axi_bready = 1'b0;
    b_after = !s_axi_bvalid && s_axi_awready;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [3:0] id, input bit toggle);
    int t, k;
    logic [31:0] pd;
    logic pl;
    bit pstall;
    rd_n = 0; r_hold_err = 0; r_tmo = 0;
    @(negedge aclk);
    s_axi_arvalid = 1'b1; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arburst = burst; s_axi_arid = id; s_axi_arsize = 3'd2;
    t = 0;
    while (!s_axi_arready && t < 50) begin @(negedge aclk); t++; end
    if (t >= 50) r_tmo = 1;
    @(negedge aclk);
    s_axi_arvalid = 1'b0;
    r_first = s_axi_rvalid;
    k = 0; pstall = 0; pd = '0; pl = 1'b0;
    while (rd_n < int'(len) + 1 && rd_n < 16 && k < 200) begin
      s_axi_rready = toggle ? (k % 2 == 0) : 1'b1;
      if (pstall && (s_axi_rvalid !== 1'b1 || s_axi_rdata !== pd || s_axi_rlast !== pl)) r_hold_err++;
      if (s_axi_rvalid && s_axi_rready) begin
        rd_d[rd_n] = s_axi_rdata; rd_resp[rd_n] = s_axi_rresp;
        rd_last[rd_n] = s_axi_rlast; rd_id[rd_n] = s_axi_rid;
        rd_n++; pstall = 0;
      end else if (s_axi_rvalid) begin
        pstall = 1; pd = s_axi_rdata; pl = s_axi_rlast;
      end
      @(negedge aclk);
      k++;
    end
    if (k >= 200) r_tmo = 1;
    s_axi_rready = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    checks++; if (s_axi_awready !== 1'b0) $display("FAIL rst_awready got %b want 0", s_axi_awready); else passed++;
    checks++; if (s_axi_wready !== 1'b0) $display("FAIL rst_wready got %b want 0", s_axi_wready); else passed++;
    checks++; if (s_axi_bvalid !== 1'b0) $display("FAIL rst_bvalid got %b want 0", s_axi_bvalid); else passed++;
    checks++; if (s_axi_arready !== 1'b0) $display("FAIL rst_arready got %b want 0", s_axi_arready); else passed++;
    checks++; if (s_axi_rvalid !== 1'b0) $display("FAIL rst_rvalid got %b want 0", s_axi_rvalid); else passed++;
    checks++; if (s_axi_rlast !== 1'b0) $display("FAIL rst_rlast got %b want 0", s_axi_rlast); else passed++;
    checks++; if (s_axi_bid !== 4'h0 || s_axi_bresp !== 2'b00) $display("FAIL rst_b got %h/%b want 0/00", s_axi_bid, s_axi_bresp); else passed++;
    checks++; if (s_axi_rid !== 4'h0 || s_axi_rresp !== 2'b00) $display("FAIL rst_r got %h/%b want 0/00", s_axi_rid, s_axi_rresp); else passed++;
    checks++; if (s_axi_rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", s_axi_rdata); else passed++;
    aresetn = 1'b1;
    @(negedge aclk);
    checks++; if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1)
      $display("FAIL rst_release got aw=%b ar=%b want 1/1", s_axi_awready, s_axi_arready); else passed++;
  endtask

  task automatic test_w_before_aw();
    int seen;
    seen = 0;
    @(negedge aclk);
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'hFFFF_FFFF; s_axi_wstrb = 4'hF;
    repeat (3) begin @(negedge aclk); if (s_axi_wready) seen++; end
    s_axi_wvalid = 1'b0;
    checks++; if (seen !== 0) $display("FAIL w_before_aw wready cycles got %0d want 0", seen); else passed++;
  endtask

  task automatic test_single();
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    do_write(32'h10, 8'd0, 2'b01, 4'h5, 0);
    checks++; if (w_tmo !== 1'b0) $display("FAIL single_wtimeout got %b want 0", w_tmo); else passed++;
    checks++; if (w_first !== 1'b1) $display("FAIL single_wready_n1 got %b want 1", w_first); else passed++;
    checks++; if (b_id !== 4'h5 || b_resp !== 2'b00) $display("FAIL single_b got %h/%b want 5/00", b_id, b_resp); else passed++;
    checks++; if (b_after !== 1'b1) $display("FAIL single_b_release got %b want 1", b_after); else passed++;
    do_read(32'h10, 8'd0, 2'b01, 4'h9, 0);
    checks++; if (r_tmo !== 1'b0 || rd_n !== 1) $display("FAIL single_rbeats got %0d tmo=%b want 1", rd_n, r_tmo); else passed++;
    checks++; if (r_first !== 1'b1) $display("FAIL single_rvalid_n1 got %b want 1", r_first); else passed++;
    checks++; if (rd_d[0] !== 32'hDEAD_BEEF) $display("FAIL single_rdata got %h want deadbeef", rd_d[0]); else passed++;
    checks++; if (rd_last[0] !== 1'b1 || rd_id[0] !== 4'h9 || rd_resp[0] !== 2'b00)
      $display("FAIL single_rmeta got last=%b id=%h resp=%b want 1/9/00", rd_last[0], rd_id[0], rd_resp[0]); else passed++;
  endtask

  task automatic test_partial();
    wd[0] = 32'h1122_3344; ws[0] = 4'hF;
    do_write(32'h20, 8'd0, 2'b01, 4'h1, 0);
    wd[0] = 32'h0000_AB00; ws[0] = 4'b0010;
    do_write(32'h20, 8'd0, 2'b01, 4'h1, 0);
    do_read(32'h20, 8'd0, 2'b01, 4'h1, 0);
    checks++; if (rd_d[0] !== 32'h1122_AB44) $display("FAIL partial_rdata got %h want 1122ab44", rd_d[0]); else passed++;
  endtask

  task automatic test_incr_stall();
    logic [31:0] exp_d [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
    logic        exp_l [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write(32'h40, 8'd3, 2'b01, 4'h2, 0);
    checks++; if (b_resp !== 2'b00 || b_id !== 4'h2) $display("FAIL incr_b got %h/%b want 2/00", b_id, b_resp); else passed++;
    do_read(32'h40, 8'd3, 2'b01, 4'h6, 1);
    checks++; if (rd_n !== 4 || r_tmo !== 1'b0) $display("FAIL incr_beats got %0d want 4", rd_n); else passed++;
    checks++; if (r_hold_err !== 0) $display("FAIL incr_stall_hold got %0d errors want 0", r_hold_err); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_d[i] !== exp_d[i] || rd_last[i] !== exp_l[i])
        $display("FAIL incr_beat%0d got %h/last=%b want %h/%b", i, rd_d[i], rd_last[i], exp_d[i], exp_l[i]); else passed++;
    end
  endtask

  task automatic test_fixed();
    wd[0] = 32'hCAFE_F00D; ws[0] = 4'hF;
    do_write(32'h84, 8'd0, 2'b01, 4'h0, 0);
    wd[0] = 32'd5; wd[1] = 32'd6; wd[2] = 32'd7;
    ws[0] = 4'hF;  ws[1] = 4'hF;  ws[2] = 4'hF;
    do_write(32'h80, 8'd2, 2'b00, 4'hA, 0);
    checks++; if (b_id !== 4'hA || b_resp !== 2'b00) $display("FAIL fixed_b got %h/%b want a/00", b_id, b_resp); else passed++;
    do_read(32'h80, 8'd0, 2'b01, 4'h0, 0);
    checks++; if (rd_d[0] !== 32'd7) $display("FAIL fixed_0x80 got %h want 7", rd_d[0]); else passed++;
    do_read(32'h84, 8'd0, 2'b01, 4'h0, 0);
    checks++; if (rd_d[0] !== 32'hCAFE_F00D) $display("FAIL fixed_0x84 got %h want cafef00d", rd_d[0]); else passed++;
  endtask

  task automatic test_concurrent();
    wd[0] = 32'hA0A0_0001; wd[1] = 32'hA0A0_0002; ws[0] = 4'hF; ws[1] = 4'hF;
    fork
      do_write(32'h100, 8'd1, 2'b01, 4'h3, 5);
      do_read(32'h40, 8'd3, 2'b01, 4'h7, 0);
    join
    checks++; if (b_hold_err !== 0) $display("FAIL conc_bvalid_hold got %0d errors want 0", b_hold_err); else passed++;
    checks++; if (aw_err !== 0) $display("FAIL conc_awready_low got %0d errors want 0", aw_err); else passed++;
    checks++; if (b_id !== 4'h3 || b_resp !== 2'b00 || b_after !== 1'b1)
      $display("FAIL conc_b got %h/%b rel=%b want 3/00/1", b_id, b_resp, b_after); else passed++;
    checks++; if (rd_n !== 4 || rd_d[0] !== 32'd1 || rd_d[3] !== 32'd4 || rd_id[3] !== 4'h7 || rd_last[3] !== 1'b1)
      $display("FAIL conc_read got n=%0d d0=%h d3=%h id=%h want 4/1/4/7", rd_n, rd_d[0], rd_d[3], rd_id[3]); else passed++;
    do_read(32'h100, 8'd1, 2'b01, 4'h0, 0);
    checks++; if (rd_d[0] !== 32'hA0A0_0001 || rd_d[1] !== 32'hA0A0_0002)
      $display("FAIL conc_wdata got %h %h want a0a00001 a0a00002", rd_d[0], rd_d[1]); else passed++;
  endtask

  task automatic test_range();
    wd[0] = 32'h1234_5678; ws[0] = 4'hF;
    do_write(32'h0, 8'd0, 2'b01, 4'h0, 0);
    wd[0] = 32'h5555_AAAA; ws[0] = 4'hF;
    do_write(32'h1000, 8'd0, 2'b01, 4'hC, 0);
`ifdef AXI_SLAVE_RANGE_CHECK_EN
    checks++; if (b_resp !== 2'b10 || b_id !== 4'hC) $display("FAIL range_bresp got %h/%b want c/10", b_id, b_resp); else passed++;
    do_read(32'h1000, 8'd0, 2'b01, 4'hD, 0);
    checks++; if (rd_resp[0] !== 2'b10 || rd_d[0] !== 32'h0) $display("FAIL range_rresp got %b/%h want 10/0", rd_resp[0], rd_d[0]); else passed++;
    do_read(32'h0, 8'd0, 2'b01, 4'hD, 0);
    checks++; if (rd_d[0] !== 32'h1234_5678) $display("FAIL range_word0 got %h want 12345678", rd_d[0]); else passed++;
`else
    checks++; if (b_resp !== 2'b00 || b_id !== 4'hC) $display("FAIL alias_bresp got %h/%b want c/00", b_id, b_resp); else passed++;
    do_read(32'h1000, 8'd0, 2'b01, 4'hD, 0);
    checks++; if (rd_resp[0] !== 2'b00 || rd_d[0] !== 32'h5555_AAAA) $display("FAIL alias_rresp got %b/%h want 00/5555aaaa", rd_resp[0], rd_d[0]); else passed++;
    do_read(32'h0, 8'd0, 2'b01, 4'hD, 0);
    checks++; if (rd_d[0] !== 32'h5555_AAAA) $display("FAIL alias_word0 got %h want 5555aaaa", rd_d[0]); else passed++;
`endif
  endtask

  task automatic test_reset_abort();
    int seen;
    @(negedge aclk);
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h200; s_axi_awlen = 8'd3; s_axi_awburst = 2'b01; s_axi_awid = 4'h2;
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h40;  s_axi_arlen = 8'd3; s_axi_arburst = 2'b01; s_axi_arid = 4'h4;
    @(negedge aclk);
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    checks++; if (s_axi_wready !== 1'b1 || s_axi_rvalid !== 1'b1)
      $display("FAIL abort_started got wready=%b rvalid=%b want 1/1", s_axi_wready, s_axi_rvalid); else passed++;
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h0BAD_0BAD; s_axi_wstrb = 4'hF;
    @(negedge aclk);
    s_axi_wvalid = 1'b0;
    aresetn = 1'b0;
    @(negedge aclk);
    checks++; if (s_axi_wready !== 1'b0 || s_axi_rvalid !== 1'b0 || s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b0)
      $display("FAIL abort_reset got w=%b r=%b b=%b aw=%b want 0", s_axi_wready, s_axi_rvalid, s_axi_bvalid, s_axi_awready); else passed++;
    aresetn = 1'b1;
    seen = 0;
    repeat (4) begin @(negedge aclk); if (s_axi_bvalid || s_axi_rvalid) seen++; end
    checks++; if (seen !== 0) $display("FAIL abort_no_resp got %0d response cycles want 0", seen); else passed++;
    checks++; if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1)
      $display("FAIL abort_idle got aw=%b ar=%b want 1/1", s_axi_awready, s_axi_arready); else passed++;
  endtask

  initial begin
    aresetn = 1'b0;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd2; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'd2; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    test_reset();
    test_w_before_aw();
    test_single();
    test_partial();
    test_incr_stall();
    test_fixed();
    test_concurrent();
    test_range();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/axi4_slave_ram.md
# axi4_slave_ram

AXI4 slave memory responder: the subordinate end of the AXI4 link driven by the PicoRV32 AXI4 master. It accepts single-beat and INCR/FIXED bursts on independent write and read paths, stores data in an internal word-addressed array, and returns B and R responses. It sits behind the SoC interconnect as the main instruction and data RAM.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width; only 32 is supported
- ID_WIDTH, 4, AXI ID width
- MEM_DEPTH, 1024, number of DATA_WIDTH words in the array
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  reset; synchronous, active-low
- s_axi_awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address channel
- s_axi_awvalid  in  1; s_axi_awready  out  1
- s_axi_wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  write data channel
- s_axi_wvalid  in  1; s_axi_wready  out  1
- s_axi_bid/bresp  out  ID_WIDTH/2; s_axi_bvalid  out  1; s_axi_bready  in  1
- s_axi_arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  read address channel
- s_axi_arvalid  in  1; s_axi_arready  out  1
- s_axi_rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1; s_axi_rvalid  out  1; s_axi_rready  in  1

## Operation
- Two independent FSMs; write and read paths proceed concurrently.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On AW handshake latch awid, word index awaddr[ADDR_WIDTH-1:2], awlen, awburst; beat counter=0; awready<=0, wready<=1; go W_DATA.
  - W_DATA: each W handshake writes bytes enabled by wstrb to array[index]; strobe-off bytes unchanged. FIXED (00): index held; INCR (01) and WRAP (10, treated as INCR): index+1. Beat count alone ends the burst; wlast is ignored. On handshake with counter==awlen: wready<=0, bvalid<=1, bid<=latched id; go W_RESP.
  - W_RESP: hold bvalid/bid/bresp until bready; on B handshake bvalid<=0, awready<=1; go W_IDLE.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On AR handshake latch arid, index, arlen, arburst; arready<=0; rvalid<=1 next cycle with rdata=array[index], rlast=(arlen==0).
  - R_DATA: outputs held stable while rvalid && !rready. On R handshake, non-last: advance index (same rules as write), counter+1, load next rdata, rlast=(counter+1==arlen), rvalid stays 1 (back-to-back beats). Last: rvalid<=0, rlast<=0, arready<=1; go R_IDLE.
- awsize/arsize ignored; every beat is 4 bytes; low 2 address bits dropped.
- Index arithmetic: ADDR_WIDTH-2 bits; wraps modulo 2^(ADDR_WIDTH-2); array indexed modulo MEM_DEPTH unless range check is enabled.
- Same-word write and read beat in one cycle: read returns the pre-write value.
- bresp/rresp=OKAY (00) unless range check flags an error.

## Timing
- Reset (aresetn=0 at a rising edge): awready, wready, bvalid, arready, rvalid, rlast=0; bid, bresp, rid, rresp, rdata=0; FSMs to W_IDLE/R_IDLE. Array contents not reset. awready/arready rise on the first edge after release.
- Reset mid-burst aborts both transactions immediately; no B/R is issued for them.
- AW handshake at edge N -> wready=1 from N+1; W handshake accepted from N+1.
- Final W handshake at edge N -> bvalid=1 from N+1.
- AR handshake at edge N -> rvalid=1 from N+1; sustained 1 beat/cycle while rready=1.
- W beats presented before AW are not accepted (wready=0 in W_IDLE).
- One outstanding transaction per direction; no interleaving; ID echoed unchanged.

## Configuration
- AXI_SLAVE_RANGE_CHECK_EN defined: a beat whose word index >= MEM_DEPTH is not written (write) or returns rdata=0 (read); response for that burst is SLVERR (10); bresp is the OR of all beats; rresp is per beat.
- Not defined: index taken modulo MEM_DEPTH, all responses OKAY, no suppression.

## Test plan
- Single write addr 0x10, data 0xDEADBEEF, wstrb 1111, then read 0x10 -> bresp 00, bid echoed, rdata 0xDEADBEEF, rlast=1.
- Partial write wstrb 0010 data 0x0000AB00 onto 0x11223344 at 0x20 -> readback 0x1122AB44.
- INCR read awlen/arlen=3 from 0x40 after writing 1,2,3,4 with rready toggling 1,0,1,... -> rdata 1,2,3,4 in order, held during stalls, rlast only on 4th beat.
- FIXED write burst len 2 to 0x80 with data 5,6,7 -> readback 0x80 = 7, 0x84 unchanged.
- Concurrent: write burst and read burst overlapping cycles, bready=0 for 5 cycles -> bvalid held stable, read completes unaffected, awready=0 until B handshake.
- With AXI_SLAVE_RANGE_CHECK_EN, MEM_DEPTH=1024: write to 0x1000 -> bresp 10, no array change; read 0x1000 -> rresp 10, rdata 0; without macro -> aliases to word 0, OKAY.
